console_glyph_render: RTL and testbench
=======================================

Name: console_glyph_render

Overview:
- Downstream neighbour of the text-console address stage; consumes its delayed RGB stream plus the VRAM word fetched for the current character cell.
- Fetches the glyph row from a synchronous glyph ROM, selects the pixel bit, applies a blinking cursor and per-cell foreground colour, and emits a re-timed 26-bit RGB stream to the next overlay stage or VGA output.

Parameters:
- size, 16, glyph edge in pixels (power of 2); pS = $clog2(size) is local.
- BLINK_FRAMES, 30, frames between cursor blink toggles (>= 1).
- CHAR_W, 8, character-code width in VRAM word.

Ports:
- px_clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- RGBStr_i  in  26  stream: [0] Active, [1] VS, [2] HS, [12:3] YC, [22:13] XC, [25:23] RGB.
- vram_data  in  CHAR_W+3  [CHAR_W-1:0] char code, [CHAR_W+2:CHAR_W] fg colour; same-cycle aligned with RGBStr_i.
- addr_glyph  out  CHAR_W+pS  glyph ROM address {char, row}.
- glyph_data  in  size  ROM row, valid one clock after addr_glyph registers; MSB is leftmost pixel.
- bg_color  in  3  background RGB.
- enable  in  1  0 = pass stream through unchanged (same latency).
- cursor_en  in  1  cursor visible when 1.
- cursor_x  in  10-pS  cursor cell column.
- cursor_y  in  10-pS  cursor cell row.
- RGBStr_o  out  26  rendered stream.

Behaviour:
- Reset (async): RGBStr_o = 0, addr_glyph = 0, all pipeline registers = 0, frame counter = 0, blink_on = 0, VS history = 0.
- Latency: exactly 3 px_clk from RGBStr_i to RGBStr_o; bits [22:0] of the stream are delayed unmodified.
- Stage 1 (edge 1):
  - addr_glyph <= {vram_data[CHAR_W-1:0], YC[pS-1:0]}.
  - Register the column XC[pS-1:0], fg colour, stream, and cursor_hit = cursor_en & (XC[9:pS]==cursor_x) & (YC[9:pS]==cursor_y).
- Stage 2 (edge 2): the ROM returns glyph_data. Register the stage-1 values. Register bit = glyph_data[size-1-col].
- Stage 3 (edge 3), output:
  - pix = bit XOR (cursor_hit & blink_on).
  - RGB = pix ? fg : bg_color.
  - If Active = 0, RGB = 3'b000.
  - If enable = 0 (sampled at stage 1 and carried along the pipeline), RGB = input RGB, delayed.
- Blink timer:
  - Rising edge of RGBStr_i[1] (VS = 1 while the previous sample was 0) increments the frame counter.
  - When the counter is at BLINK_FRAMES-1 on an edge: counter <= 0 and blink_on toggles.
  - With BLINK_FRAMES = 1, blink_on toggles on every VS edge.
- Boundaries:
  - Cell boundary: col wraps from size-1 to 0 with a new addr_glyph on the same cycle. There are no bubbles; every clock is a new pixel.
  - A VS edge coincident with a cursor-cell pixel: blink_on changes at stage 1 timing. The pixel uses the blink_on value registered at its stage 3 edge.
  - Reset mid-frame: RGBStr_o = 0 until 3 clocks after reset deasserts. After that, output follows the input normally. Blink phase restarts at 0.
  - cursor_x/cursor_y outside the screen never match. No error is raised.

Decomposition:
- console_pkg: stream field constants (Active, VS, HS, YC, XC, RGB bit ranges), colour width 3, CHAR_W default.
- Sub-module blink_timer (px_clk, reset, vs, blink_on; parameter BLINK_FRAMES) owns the VS edge detector and frame counter.
- The glyph ROM is external.

Test Plan:
- Reset: reset=1 mid-stream → RGBStr_o = 0 and addr_glyph = 0 immediately. Release → first valid output exactly 3 clocks later.
- Glyph render: char 8'h41, YC=35 (row 3), ROM row 16'h8001, fg=3'b010, bg=3'b001. Sweep XC 32..47 → RGB = 010 at cols 0 and 15, 001 elsewhere, each 3 clocks after input. addr_glyph = {8'h41, 4'd3}.
- Blanking: Active=0 with glyph bit 1 → RGB = 000, and bits [22:0] equal the input delayed by 3.
- Cursor blink:
  - BLINK_FRAMES=2, cursor at (2,1), glyph all zeros, fg=111, bg=000.
  - After 2 VS rising edges, pixels with XC 32..47, YC 16..31 → RGB=111. Other cells → 000.
  - After 2 more VS edges the cursor cell → 000 again.
- Pass-through: enable=0, random stream → RGBStr_o equals RGBStr_i delayed 3 clocks, bit-exact.
- Cursor disabled: cursor_en=0 with blink_on=1 at the cursor cell → output equals normal glyph rendering.

Source files
------------

// File: rtl/console_pkg.sv
// Stream field layout and shared widths for the text-console pixel pipeline.
package console_pkg;
    localparam int STR_W      = 26;
    localparam int ACT_BIT    = 0;
    localparam int VS_BIT     = 1;
    localparam int YC_LSB     = 3;
    localparam int YC_MSB     = 12;
    localparam int XC_LSB     = 13;
    localparam int XC_MSB     = 22;
    localparam int RGB_LSB    = 23;
    localparam int RGB_MSB    = 25;
    localparam int COORD_W    = 10;
    localparam int COLOR_W    = 3;
    localparam int CHAR_W_DEF = 8;
endpackage

// File: rtl/blink_timer.sv
// Cursor blink phase: counts VS rising edges, toggles blink_on every BLINK_FRAMES frames.
// Latency: blink_on updates on the edge that samples the VS rise.
// Backpressure: none, free-running on px_clk.
module blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic px_clk,
    input  logic reset,
    input  logic vs,
    output logic blink_on
);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic             vs_q;
    logic [CNT_W-1:0] frame_cnt;
    logic             vs_rise;

    assign vs_rise = vs & ~vs_q;

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            vs_q      <= 1'b0;
            frame_cnt <= '0;
            blink_on  <= 1'b0;
        end else begin
            vs_q <= vs;
            if (vs_rise) begin
                // With BLINK_FRAMES == 1 the compare is always true: toggle every frame.
                if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/console_glyph_render.sv
// Renders text-console glyph pixels (glyph ROM lookup, blinking cursor, fg/bg colour) into the RGB stream.
// Latency: 3 px_clk from RGBStr_i to RGBStr_o; bits [22:0] are delayed unmodified.
// Backpressure: none, one pixel per clock with no bubbles.
module console_glyph_render
    import console_pkg::*;
#(
    parameter int size         = 16,
    parameter int BLINK_FRAMES = 30,
    parameter int CHAR_W       = CHAR_W_DEF,
    localparam int pS          = $clog2(size)
) (
    input  logic                      px_clk,
    input  logic                      reset,
    input  logic [STR_W-1:0]          RGBStr_i,
    input  logic [CHAR_W+COLOR_W-1:0] vram_data,
    output logic [CHAR_W+pS-1:0]      addr_glyph,
    input  logic [size-1:0]           glyph_data,
    input  logic [COLOR_W-1:0]        bg_color,
    input  logic                      enable,
    input  logic                      cursor_en,
    input  logic [COORD_W-pS-1:0]     cursor_x,
    input  logic [COORD_W-pS-1:0]     cursor_y,
    output logic [STR_W-1:0]          RGBStr_o
);
    logic [COORD_W-1:0] xc;
    logic [COORD_W-1:0] yc;
    logic               cursor_hit;

    assign xc = RGBStr_i[XC_MSB:XC_LSB];
    assign yc = RGBStr_i[YC_MSB:YC_LSB];
    assign cursor_hit = cursor_en && (xc[COORD_W-1:pS] == cursor_x)
                                  && (yc[COORD_W-1:pS] == cursor_y);

    logic [STR_W-1:0]   s1_str, s2_str;
    logic [pS-1:0]      s1_col, s2_col;
    logic [COLOR_W-1:0] s1_fg, s2_fg;
    logic               s1_hit, s2_hit;
    logic               s1_en, s2_en;
    logic               blink_on;

    blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .px_clk  (px_clk),
        .reset   (reset),
        .vs      (RGBStr_i[VS_BIT]),
        .blink_on(blink_on)
    );

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            addr_glyph <= '0;
            s1_str     <= '0;
            s1_col     <= '0;
            s1_fg      <= '0;
            s1_hit     <= 1'b0;
            s1_en      <= 1'b0;
            s2_str     <= '0;
            s2_col     <= '0;
            s2_fg      <= '0;
            s2_hit     <= 1'b0;
            s2_en      <= 1'b0;
        end else begin
            addr_glyph <= {vram_data[CHAR_W-1:0], yc[pS-1:0]};
            s1_str     <= RGBStr_i;
            s1_col     <= xc[pS-1:0];
            s1_fg      <= vram_data[CHAR_W+COLOR_W-1:CHAR_W];
            s1_hit     <= cursor_hit;
            s1_en      <= enable;
            s2_str     <= s1_str;
            s2_col     <= s1_col;
            s2_fg      <= s1_fg;
            s2_hit     <= s1_hit;
            s2_en      <= s1_en;
        end
    end

    // The ROM's own output register is the stage-2 register for the glyph row,
    // so the pixel bit is selected from glyph_data with the stage-2 column.
    logic               pix_bit;
    logic               pix;
    logic [COLOR_W-1:0] rgb_nxt;

    always_comb begin
        pix_bit = glyph_data[pS'(size - 1) - s2_col];
        pix     = pix_bit ^ (s2_hit & blink_on);
        rgb_nxt = pix ? s2_fg : bg_color;
        if (!s2_str[ACT_BIT]) begin
            rgb_nxt = '0;
        end
        if (!s2_en) begin
            rgb_nxt = s2_str[RGB_MSB:RGB_LSB];
        end
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            RGBStr_o <= '0;
        end else begin
            RGBStr_o <= {rgb_nxt, s2_str[XC_MSB:0]};
        end
    end
endmodule

// File: tb/tb_console_glyph_render.sv
// Directed table-driven bench for console_glyph_render (size 16, BLINK_FRAMES 2, cursor at cell (2,1)).
module tb_console_glyph_render;
    logic        px_clk = 1'b0;
    logic        reset = 1'b0;
    logic [25:0] RGBStr_i;
    logic [10:0] vram_data;
    logic [11:0] addr_glyph;
    logic [15:0] glyph_data;
    logic [2:0]  bg_color;
    logic        enable;
    logic        cursor_en;
    logic [5:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic [25:0] RGBStr_o;

    int checks = 0;
    int errors = 0;

    console_glyph_render #(
        .size(16),
        .BLINK_FRAMES(2),
        .CHAR_W(8)
    ) dut (
        .px_clk    (px_clk),
        .reset     (reset),
        .RGBStr_i  (RGBStr_i),
        .vram_data (vram_data),
        .addr_glyph(addr_glyph),
        .glyph_data(glyph_data),
        .bg_color  (bg_color),
        .enable    (enable),
        .cursor_en (cursor_en),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .RGBStr_o  (RGBStr_o)
    );

    always #5 px_clk = ~px_clk;

    function automatic logic [15:0] rom(input logic [11:0] a);
        if (a[11:4] == 8'h41 && a[3:0] == 4'd3) return 16'h8001;
        if (a[11:4] == 8'hFF) return 16'hFFFF;
        return 16'h0000;
    endfunction

    always @(posedge px_clk) glyph_data <= rom(addr_glyph);

    typedef struct {
        logic [25:0] str;
        logic [10:0] vram;
        logic        en;
        logic        cen;
        logic [2:0]  exp_rgb;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [25:0] mk(input logic act, input logic vs, input int xc,
                                       input int yc, input logic [2:0] rgb);
        return {rgb, 10'(xc), 10'(yc), 1'b0, vs, act};
    endfunction

    function automatic void add(input logic act, input logic vs, input int xc, input int yc,
                                input logic [2:0] rgb, input logic [7:0] ch, input logic [2:0] fg,
                                input logic en, input logic cen, input logic [2:0] exp_rgb);
        vec_t v;
        v.str     = mk(act, vs, xc, yc, rgb);
        v.vram    = {fg, ch};
        v.en      = en;
        v.cen     = cen;
        v.exp_rgb = exp_rgb;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive_idle();
        RGBStr_i  = '0;
        vram_data = '0;
        enable    = 1'b1;
        cursor_en = 1'b0;
    endtask

    // Streams the table one pixel per clock; output of vector k is due after edge k+2.
    task automatic run_vectors(input string nm);
        int n = vecs.size();
        for (int k = 0; k < n + 2; k++) begin
            if (k < n) begin
                RGBStr_i  = vecs[k].str;
                vram_data = vecs[k].vram;
                enable    = vecs[k].en;
                cursor_en = vecs[k].cen;
            end else begin
                drive_idle();
            end
            @(posedge px_clk);
            #1;
            if (k < n)
                chk({nm, " addr"}, 32'(addr_glyph), 32'({vecs[k].vram[7:0], vecs[k].str[6:3]}));
            if (k >= 2)
                chk(nm, 32'(RGBStr_o), 32'({vecs[k-2].exp_rgb, vecs[k-2].str[22:0]}));
            else
                chk({nm, " latency"}, 32'(RGBStr_o), 32'd0);
        end
        vecs.delete();
    endtask

    task automatic vs_pulse();
        RGBStr_i  = mk(1'b0, 1'b1, 0, 0, 3'b000);
        vram_data = '0;
        enable    = 1'b1;
        cursor_en = 1'b0;
        @(posedge px_clk);
        #1;
        drive_idle();
        repeat (3) @(posedge px_clk);
        #1;
    endtask

    // Cursor cell (2,1) pixels with an empty glyph: colour follows blink_on alone.
    function automatic void add_cursor_cell(input logic [2:0] exp_rgb);
        add(1'b1, 1'b0, 32, 16, 3'b000, 8'h00, 3'b111, 1'b1, 1'b1, exp_rgb);
        add(1'b1, 1'b0, 47, 31, 3'b000, 8'h00, 3'b111, 1'b1, 1'b1, exp_rgb);
    endfunction

    initial begin
        drive_idle();
        bg_color = 3'b001;
        cursor_x = 6'd2;
        cursor_y = 6'd1;
        #1 reset = 1'b1;
        #1;
        chk("reset out", 32'(RGBStr_o), 32'd0);
        chk("reset addr", 32'(addr_glyph), 32'd0);
        repeat (2) @(posedge px_clk);
        #1 reset = 1'b0;

        // Glyph row 3 of 'A' = 8001: fg at columns 0 and 15, wrap into next cell at XC 48.
        for (int x = 32; x <= 49; x++)
            add(1'b1, 1'b0, x, 35, 3'b101, 8'h41, 3'b010, 1'b1, 1'b0,
                (x == 32 || x == 47 || x == 48) ? 3'b010 : 3'b001);
        run_vectors("glyph");

        // Blanking forces black even on lit glyph bits; enable=0 still passes the input colour.
        for (int x = 40; x <= 43; x++)
            add(1'b0, 1'b0, x, 35, 3'b110, 8'hFF, 3'b111, 1'b1, 1'b0, 3'b000);
        add(1'b0, 1'b0, 44, 35, 3'b110, 8'hFF, 3'b111, 1'b0, 1'b0, 3'b110);
        run_vectors("blank");

        for (int i = 0; i < 8; i++) begin
            vec_t v;
            v.str     = 26'($urandom());
            v.vram    = 11'($urandom());
            v.en      = 1'b0;
            v.cen     = 1'($urandom());
            v.exp_rgb = v.str[25:23];
            vecs.push_back(v);
        end
        run_vectors("passthru");

        // Mid-frame reset with pixels in flight.
        RGBStr_i  = mk(1'b1, 1'b0, 32, 35, 3'b101);
        vram_data = {3'b010, 8'h41};
        enable    = 1'b1;
        repeat (3) @(posedge px_clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset out", 32'(RGBStr_o), 32'd0);
        chk("midreset addr", 32'(addr_glyph), 32'd0);
        @(posedge px_clk);
        #1;
        chk("midreset hold", 32'(RGBStr_o), 32'd0);
        reset = 1'b0;
        add(1'b1, 1'b0, 32, 35, 3'b101, 8'h41, 3'b010, 1'b1, 1'b0, 3'b010);
        add(1'b1, 1'b0, 33, 35, 3'b101, 8'h41, 3'b010, 1'b1, 1'b0, 3'b001);
        run_vectors("postreset");

        bg_color = 3'b000;
        add_cursor_cell(3'b000);
        run_vectors("blink0");
        vs_pulse();
        add_cursor_cell(3'b000);
        run_vectors("blink1edge");
        vs_pulse();

        // blink_on = 1: cursor cell lit, neighbours dark, cursor inverts lit glyph bits.
        add_cursor_cell(3'b111);
        add(1'b1, 1'b0, 40, 24, 3'b000, 8'h00, 3'b111, 1'b1, 1'b1, 3'b111);
        add(1'b1, 1'b0, 48, 16, 3'b000, 8'h00, 3'b111, 1'b1, 1'b1, 3'b000);
        add(1'b1, 1'b0, 31, 20, 3'b000, 8'h00, 3'b111, 1'b1, 1'b1, 3'b000);
        add(1'b1, 1'b0, 40, 32, 3'b000, 8'h00, 3'b111, 1'b1, 1'b1, 3'b000);
        add(1'b1, 1'b0, 40, 15, 3'b000, 8'h00, 3'b111, 1'b1, 1'b1, 3'b000);
        add(1'b1, 1'b0, 33, 17, 3'b000, 8'hFF, 3'b111, 1'b1, 1'b1, 3'b000);
        add(1'b1, 1'b0, 60, 17, 3'b000, 8'hFF, 3'b111, 1'b1, 1'b1, 3'b111);
        add(1'b1, 1'b0, 34, 18, 3'b000, 8'hFF, 3'b111, 1'b1, 1'b0, 3'b111);
        add(1'b1, 1'b0, 35, 18, 3'b000, 8'h00, 3'b111, 1'b1, 1'b0, 3'b000);
        run_vectors("blinkon");

        vs_pulse();
        vs_pulse();
        add_cursor_cell(3'b000);
        run_vectors("blinkoff");

        // VS rise on a cursor pixel: the toggle is visible to that pixel and the one before it.
        vs_pulse();
        add(1'b1, 1'b0, 60, 16, 3'b000, 8'h00, 3'b111, 1'b1, 1'b1, 3'b000);
        add(1'b1, 1'b0, 47, 31, 3'b000, 8'h00, 3'b111, 1'b1, 1'b1, 3'b111);
        add(1'b1, 1'b1, 32, 16, 3'b000, 8'h00, 3'b111, 1'b1, 1'b1, 3'b111);
        add(1'b1, 1'b1, 36, 16, 3'b000, 8'h00, 3'b111, 1'b1, 1'b1, 3'b111);
        run_vectors("vscoinc");

        // Reset restarts the blink phase at off.
        reset = 1'b1;
        @(posedge px_clk);
        #1 reset = 1'b0;
        add_cursor_cell(3'b000);
        run_vectors("blinkreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
